// File: rtl/apb_ctrl_master_if.sv
// Command/response handshake plus APB bus bundle for apb_ctrl_master.
// The master modport is the initiator's view; slave is the fabric/completer side.
interface apb_ctrl_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_ctrl_master.sv
// APB initiator: one valid/ready command becomes one SETUP+ACCESS transfer.
// Optional ACCESS-phase timeout is enabled with `define APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready=1, bus idle, waiting for cmd_valid
// SETUP  | psel=1, penable=0
// ACCESS | psel=1, penable=1, waiting for pready (or timeout)
// RESP   | rsp_valid=1 until rsp_ready
module apb_ctrl_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_ctrl_master_if.master     bus,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   accept, complete, timeout_hit;
  logic   psel_nxt, penable_nxt, rsp_valid_nxt;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign complete = (state == ACCESS) && bus.pready;

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    psel_nxt      = (state_nxt == SETUP) || (state_nxt == ACCESS);
    penable_nxt   = (state_nxt == ACCESS);
    rsp_valid_nxt = (state_nxt == RESP);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.psel      <= psel_nxt;
      bus.penable   <= penable_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      if (accept) begin
        bus.pwrite <= bus.cmd_write;
        bus.paddr  <= bus.cmd_addr;
        bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
      end
      if (complete) begin
        bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
        bus.rsp_err   <= bus.pslverr;
      end else if (timeout_hit) begin
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= 1'b1;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Down-counter loaded at accept; terminal count in the last allowed ACCESS cycle.
  logic [TO_W-1:0] to_cnt;
  logic            rsp_timeout_q;

  assign timeout_hit = (state == ACCESS) && !bus.pready && (to_cnt == '0);

  always_ff @(posedge pclk) begin
    if (preset) begin
      to_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept)
        to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
      else if ((state == ACCESS) && !bus.pready && (to_cnt != '0))
        to_cnt <= to_cnt - TO_W'(1);
      if (complete)         rsp_timeout_q <= 1'b0;
      else if (timeout_hit) rsp_timeout_q <= 1'b1;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign timeout_hit        = 1'b0;
  assign bus.rsp_timeout    = 1'b0;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);

endmodule
